// File: rtl/dma_reg_read.sv
// dma_reg_read: 8237A CPU read port; returns address/count/status/temp bytes and
// owns the byte-pointer flip-flop and terminal-count latches.
module dma_reg_read #(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              masterClear,
  input  logic              Program,
  input  logic              CS_N,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic [3:0]        ioAddr,
  input  logic [NCH*AW-1:0] curAddr,
  input  logic [NCH*AW-1:0] curWordCount,
  input  logic [7:0]        tempReg,
  input  logic [NCH-1:0]    dreqStatus,
  input  logic [NCH-1:0]    tcPulse,
  input  logic              wrByteAccess,
  input  logic              clearFF,
  output logic [7:0]        dbOut,
  output logic              dbOE,
  output logic [7:0]        statusReg,
  output logic              bytePtr
);
  typedef enum logic {IDLE, READ} state_t;
  state_t         state_q, state_d;
  logic [7:0]     db_q, db_d, sel_data;
  logic [3:0]     addr_q, addr_d;
  logic           bp_q, bp_d;
  logic [NCH-1:0] tc_q, tc_d, clr_mask;
  logic [AW-1:0]  word;
  logic [1:0]     ch;
  logic           read_sel, rd_start, rd_end;
  assign read_sel  = Program & ~CS_N & ~IOR_N & IOW_N;
  assign rd_start  = (state_q == IDLE) & read_sel;
  assign rd_end    = (state_q == READ) & ~read_sel;
  assign statusReg = {dreqStatus, tc_q};
  assign dbOut     = db_q;
  assign dbOE      = (state_q == READ);
  assign bytePtr   = bp_q;
  always_comb begin
    ch       = ioAddr[2:1];
    word     = ioAddr[0] ? curWordCount[ch*AW +: AW] : curAddr[ch*AW +: AW];
    sel_data = !ioAddr[3]       ? (bp_q ? word[15:8] : word[7:0]) :
               ioAddr == 4'h8   ? statusReg :
               ioAddr == 4'hD   ? tempReg : 8'h00;
  end
  // Only the TC bits that were captured into the read data get cleared.
  always_comb begin
    clr_mask = (rd_end && addr_q == 4'h8) ? db_q[NCH-1:0] : '0;
    tc_d     = masterClear ? '0 : (tc_q & ~clr_mask) | tcPulse;
    bp_d     = (masterClear | clearFF) ? 1'b0 :
               bp_q ^ ((rd_end & ~addr_q[3]) | wrByteAccess);
    state_d  = (read_sel & ~masterClear) ? READ : IDLE;
    db_d     = masterClear ? 8'h00 : rd_start ? sel_data : db_q;
    addr_d   = masterClear ? 4'h0 : rd_start ? ioAddr : addr_q;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      db_q    <= 8'h00;
      addr_q  <= 4'h0;
      bp_q    <= 1'b0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      addr_q  <= addr_d;
      bp_q    <= bp_d;
      tc_q    <= tc_d;
    end
  end
endmodule

// File: tb/tb_dma_reg_read.sv
// tb_dma_reg_read: directed reads with a scoreboard of expected read bytes.
module tb_dma_reg_read;
  logic        CLK = 0, RESET_N = 0, masterClear = 0, Program = 1;
  logic        CS_N = 1, IOR_N = 1, IOW_N = 1;
  logic [3:0]  ioAddr = 0;
  logic [63:0] curAddr = 0, curWordCount = 0;
  logic [7:0]  tempReg = 0;
  logic [3:0]  dreqStatus = 0, tcPulse = 0;
  logic        wrByteAccess = 0, clearFF = 0;
  logic [7:0]  dbOut, statusReg;
  logic        dbOE, bytePtr;
  int          nvec = 0, nerr = 0;
  logic [7:0]  exp_q[$];
  logic        oe_prev = 0;

  dma_reg_read dut (
    .CLK(CLK), .RESET_N(RESET_N), .masterClear(masterClear), .Program(Program),
    .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .ioAddr(ioAddr),
    .curAddr(curAddr), .curWordCount(curWordCount), .tempReg(tempReg),
    .dreqStatus(dreqStatus), .tcPulse(tcPulse), .wrByteAccess(wrByteAccess),
    .clearFF(clearFF), .dbOut(dbOut), .dbOE(dbOE), .statusReg(statusReg),
    .bytePtr(bytePtr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, expv);
    end
  endtask

  // Monitor: each new dbOE assertion presents one read byte.
  always @(negedge CLK) begin
    if (dbOE && !oe_prev) begin
      if (exp_q.size() == 0) check("unexpected_read", dbOut, 8'hxx);
      else check("read_data", dbOut, exp_q.pop_front());
    end
    oe_prev = dbOE;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_read(input logic [3:0] a, input logic [7:0] e);
    tick();
    ioAddr = a; CS_N = 0; IOR_N = 0;
    exp_q.push_back(e);
    repeat (2) tick();
  endtask

  task automatic end_read();
    CS_N = 1; IOR_N = 1;
    tick();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e);
    start_read(a, e);
    end_read();
  endtask

  initial begin
    repeat (2) tick();
    check("reset_dbOut", dbOut, 8'h00);
    check("reset_dbOE", {7'b0, dbOE}, 8'h00);
    check("reset_bytePtr", {7'b0, bytePtr}, 8'h00);
    check("reset_status", statusReg, 8'h00);
    RESET_N = 1;
    tick();
    // Address byte sequencing
    curAddr[47:32] = 16'hBEEF;
    do_read(4'h4, 8'hEF);
    check("bp_after_lo", {7'b0, bytePtr}, 8'h01);
    do_read(4'h4, 8'hBE);
    check("bp_after_hi", {7'b0, bytePtr}, 8'h00);
    // Word count and clear byte pointer
    curWordCount[31:16] = 16'h1234;
    do_read(4'h3, 8'h34);
    do_read(4'h3, 8'h12);
    do_read(4'h3, 8'h34);
    clearFF = 1; tick(); clearFF = 0;
    check("bp_after_clearFF", {7'b0, bytePtr}, 8'h00);
    do_read(4'h3, 8'h34);
    check("bp_after_wc", {7'b0, bytePtr}, 8'h01);
    clearFF = 1; tick(); clearFF = 0;
    // Status and TC latches
    dreqStatus = 4'h5;
    tcPulse = 4'b0010; tick(); tcPulse = 0;
    check("status_tc1", statusReg, 8'h52);
    do_read(4'h8, 8'h52);
    check("status_cleared", statusReg, 8'h50);
    check("bp_status_read", {7'b0, bytePtr}, 8'h00);
    tcPulse = 4'b1000; tick(); tcPulse = 0;
    start_read(4'h8, 8'h58);
    CS_N = 1; IOR_N = 1; tcPulse = 4'b1000;
    tick(); tcPulse = 0;
    check("tc_set_wins", statusReg, 8'h58);
    start_read(4'h8, 8'h58);
    tcPulse = 4'b0001; tick(); tcPulse = 0;
    end_read();
    check("tc_mid_strobe_kept", statusReg, 8'h51);
    // Temp register and unmapped address
    tempReg = 8'hA5;
    do_read(4'hD, 8'hA5);
    check("bp_temp_read", {7'b0, bytePtr}, 8'h00);
    start_read(4'hA, 8'h00);
    check("unmapped_oe", {7'b0, dbOE}, 8'h01);
    end_read();
    check("unmapped_bp", {7'b0, bytePtr}, 8'h00);
    check("unmapped_status", statusReg, 8'h51);
    // Frozen data and async reset mid-strobe
    curAddr[15:0] = 16'h1122;
    start_read(4'h0, 8'h22);
    curAddr[15:0] = 16'h3344;
    tick();
    check("frozen_data", dbOut, 8'h22);
    #2 RESET_N = 0; #1;
    check("async_oe", {7'b0, dbOE}, 8'h00);
    check("async_bp", {7'b0, bytePtr}, 8'h00);
    check("async_status", statusReg, 8'h50);
    CS_N = 1; IOR_N = 1;
    tick(); RESET_N = 1; tick();
    check("post_reset_bp", {7'b0, bytePtr}, 8'h00);
    // Write-side byte pointer interaction
    wrByteAccess = 1; tick(); wrByteAccess = 0;
    check("wr_toggle", {7'b0, bytePtr}, 8'h01);
    do_read(4'h0, 8'h33);
    check("bp_after_hi_read", {7'b0, bytePtr}, 8'h00);
    wrByteAccess = 1; clearFF = 1; tick(); wrByteAccess = 0; clearFF = 0;
    check("clearFF_priority", {7'b0, bytePtr}, 8'h00);
    start_read(4'h0, 8'h44);
    CS_N = 1; IOR_N = 1; wrByteAccess = 1;
    tick(); wrByteAccess = 0;
    check("single_toggle", {7'b0, bytePtr}, 8'h01);
    // Master clear
    tcPulse = 4'b0100; tick(); tcPulse = 0;
    masterClear = 1; tick(); masterClear = 0;
    check("mc_bp", {7'b0, bytePtr}, 8'h00);
    check("mc_status", statusReg, 8'h50);
    check("mc_dbOut", dbOut, 8'h00);
    repeat (2) tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
